// File: rtl/imem_boot_loader.sv
// Streams a byte-wide program image into instruction RAM as little-endian 32-bit words,
// then releases the core from reset. Every output is decoded from registered state.
module imem_boot_loader #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  core_reset_,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t                state, state_next;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word;
  logic                  last_seen;
  logic [ADDR_WIDTH:0]   count;
  logic                  xfer;

  // byte_ready is 1 exactly in LOAD, so the handshake reduces to valid while loading.
  assign xfer = byte_valid && (state == LOAD);

  // NOTE: every variable assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = LOAD;
      LOAD:  if (xfer && (byte_idx == 2'd3 || byte_last)) state_next = WRITE;
      WRITE: begin
        if (last_seen)                           state_next = DONE;
        else if (addr == ADDR_WIDTH'(DEPTH - 1)) state_next = ERR;
        else                                     state_next = LOAD;
      end
      DONE:  if (reload) state_next = IDLE;
      ERR:   state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      byte_idx  <= 2'd0;
      addr      <= '0;
      word      <= '0;
      last_seen <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx  <= byte_idx + 2'd1;
            last_seen <= byte_last;
          end
        end
        WRITE: begin
          // Clearing word here makes the missing bytes of a short final word read as 0.
          addr     <= addr + ADDR_WIDTH'(1);
          count    <= count + (ADDR_WIDTH + 1)'(1);
          byte_idx <= 2'd0;
          word     <= '0;
        end
        DONE: begin
          if (reload) begin
            addr      <= '0;
            count     <= '0;
            byte_idx  <= 2'd0;
            last_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready  = (state == LOAD);
  assign wr_en       = (state == WRITE);
  assign wr_addr     = addr;
  assign wr_data     = word;
  assign core_reset_ = (state == DONE);
  assign load_done   = (state == DONE);
  assign load_error  = (state == ERR);
  assign word_count  = count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads images of several shapes, checks written
// words, handshake, completion, overflow, asynchronous reset and reload.
module tb_imem_boot_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset_;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready;
  logic          reload;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_reset_;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  int checks    = 0;
  int failures  = 0;
  int ready_bad = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_      (reset_),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .reload      (reload),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .core_reset_ (core_reset_),
    .load_done   (load_done),
    .load_error  (load_error),
    .word_count  (word_count)
  );

  always #5 clock = ~clock;

  // Record every imem write, and flag any write cycle that also offers byte_ready.
  always @(negedge clock) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      if (byte_ready) ready_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    ready_bad = 0;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    reload     = 1'b0;
    reset_     = 1'b0;
    repeat (2) tick();
    reset_ = 1'b1;
    clear_log();
  endtask

  // Offers one byte and returns 1 ns after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 64'(n), 64'(0));
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!load_done && !load_error && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 50), 64'(1));
  endtask

  initial begin
    logic [31:0] exp_word;
    int          bad;

    // ---- 1: reset values, then a single-word image ----
    do_reset();
    reset_ = 1'b0;
    #1;
    check("rst_byte_ready", 64'(byte_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_core_reset_", 64'(core_reset_), 64'(0));
    check("rst_load_done", 64'(load_done), 64'(0));
    check("rst_load_error", 64'(load_error), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    tick();
    reset_ = 1'b1;
    clear_log();
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check("t1_wr_en", 64'(wr_en), 64'(1));
    check("t1_wr_addr", 64'(wr_addr), 64'(0));
    check("t1_wr_data", 64'(wr_data), 64'h0000_0513);
    check("t1_ready_in_write", 64'(byte_ready), 64'(0));
    check("t1_core_held", 64'(core_reset_), 64'(0));
    tick();
    check("t1_wr_en_one_cycle", 64'(wr_en), 64'(0));
    check("t1_core_reset_", 64'(core_reset_), 64'(1));
    check("t1_load_done", 64'(load_done), 64'(1));
    check("t1_word_count", 64'(word_count), 64'(1));
    check("t1_ready_in_done", 64'(byte_ready), 64'(0));
    check("t1_writes", 64'(log_addr.size()), 64'(1));

    // ---- 2: eight bytes with random valid gaps ----
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(8'(i), i == 8);
    end
    wait_end("t2_finished");
    check("t2_load_done", 64'(load_done), 64'(1));
    check("t2_writes", 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) begin
      check("t2_addr0", 64'(log_addr[0]), 64'(0));
      check("t2_data0", 64'(log_data[0]), 64'h0403_0201);
      check("t2_addr1", 64'(log_addr[1]), 64'(1));
      check("t2_data1", 64'(log_data[1]), 64'h0807_0605);
    end
    check("t2_ready_in_write", 64'(ready_bad), 64'(0));
    check("t2_word_count", 64'(word_count), 64'(2));

    // ---- 3: six bytes, partial final word zero-filled ----
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    wait_end("t3_finished");
    check("t3_writes", 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) begin
      check("t3_data0", 64'(log_data[0]), 64'h4433_2211);
      check("t3_addr1", 64'(log_addr[1]), 64'(1));
      check("t3_data1", 64'(log_data[1]), 64'h0000_6655);
    end
    check("t3_word_count", 64'(word_count), 64'(2));
    check("t3_load_done", 64'(load_done), 64'(1));

    // ---- 4: 256 bytes without last overflow into ERR ----
    do_reset();
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0);
    tick();
    check("t4_load_error", 64'(load_error), 64'(1));
    check("t4_load_done", 64'(load_done), 64'(0));
    check("t4_word_count", 64'(word_count), 64'(64));
    check("t4_writes", 64'(log_addr.size()), 64'(64));
    bad = 0;
    for (int k = 0; k < log_addr.size(); k++) begin
      exp_word = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (log_addr[k] !== AW'(k) || log_data[k] !== exp_word) bad++;
    end
    check("t4_write_contents", 64'(bad), 64'(0));
    bad = 0;
    byte_valid = 1'b1;
    reload     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (load_error !== 1'b1 || byte_ready !== 1'b0 || core_reset_ !== 1'b0) bad++;
    end
    byte_valid = 1'b0;
    reload     = 1'b0;
    check("t4_err_sticky", 64'(bad), 64'(0));

    // ---- 7: last on byte 4 of word DEPTH-1 completes instead of erroring ----
    do_reset();
    for (int i = 0; i < 256; i++) send_byte(8'(i ^ 8'h5a), i == 255);
    tick();
    check("t7_load_done", 64'(load_done), 64'(1));
    check("t7_load_error", 64'(load_error), 64'(0));
    check("t7_word_count", 64'(word_count), 64'(64));

    // ---- 5: asynchronous reset mid-load, then a clean image ----
    do_reset();
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    check("t5_ready_before", 64'(byte_ready), 64'(1));
    #2 reset_ = 1'b0;
    #1;
    check("t5_async_ready", 64'(byte_ready), 64'(0));
    check("t5_async_outputs", 64'({wr_en, wr_addr, wr_data, core_reset_, load_done, load_error, word_count}), 64'(0));
    tick();
    tick();
    reset_ = 1'b1;
    clear_log();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    wait_end("t5_finished");
    check("t5_writes", 64'(log_addr.size()), 64'(1));
    if (log_addr.size() == 1) begin
      check("t5_addr0", 64'(log_addr[0]), 64'(0));
      check("t5_data0", 64'(log_data[0]), 64'h0403_0201);
    end
    check("t5_load_done", 64'(load_done), 64'(1));

    // ---- 6: reload from DONE ----
    clear_log();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("t6_core_reset_", 64'(core_reset_), 64'(0));
    check("t6_load_done", 64'(load_done), 64'(0));
    check("t6_word_count", 64'(word_count), 64'(0));
    send_byte(8'hef, 1'b0);
    send_byte(8'hbe, 1'b0);
    send_byte(8'had, 1'b0);
    send_byte(8'hde, 1'b1);
    wait_end("t6_finished");
    check("t6_writes", 64'(log_addr.size()), 64'(1));
    if (log_addr.size() == 1) begin
      check("t6_addr0", 64'(log_addr[0]), 64'(0));
      check("t6_data0", 64'(log_data[0]), 64'hdead_beef);
    end
    check("t6_core_released", 64'(core_reset_), 64'(1));
    check("t6_word_count_end", 64'(word_count), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
